// File: rtl/blind_motor_arbiter_if.sv
// Request/grant bundle between the manual and light-sensor requesters and the
// blind motor arbiter.
interface blind_motor_arbiter_if;
  logic       user_valid;
  logic [1:0] user_pos;
  logic       auto_en;
  logic       auto_valid;
  logic [1:0] auto_pos;
  logic       grant_user;
  logic       grant_auto;

  modport master (
    output user_valid, user_pos, auto_en, auto_valid, auto_pos,
    input  grant_user, grant_auto
  );

  modport slave (
    input  user_valid, user_pos, auto_en, auto_valid, auto_pos,
    output grant_user, grant_auto
  );
endinterface

// File: rtl/blind_motor_arbiter.sv
// Blind motor arbiter: user/auto request arbitration, dead time before energising,
// limit-sensor stops and fault latch. Optional motion watchdog: PERSIANA_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | motor off, accepting requests
// DEAD    | motor off, waiting DEAD_TICKS ticks before energising
// MOVE_UP | subir driven until target sensor or upper end-stop
// MOVE_DN | bajar driven until target sensor or lower end-stop
// FAULT   | both end-stops seen together or watchdog expired; only reset exits
module blind_motor_arbiter #(
  parameter int unsigned DEAD_TICKS    = 4,
  parameter int unsigned TIMEOUT_TICKS = 200
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  blind_motor_arbiter_if.slave        req,
  input  logic                        s_inf,
  input  logic                        s_med,
  input  logic                        s_sup,
  output logic                        subir,
  output logic                        bajar,
  output logic                        busy,
  output logic                        fault,
  output logic [1:0]                  pos_cur
);
  localparam int unsigned MAX_TICKS = (DEAD_TICKS > TIMEOUT_TICKS) ? DEAD_TICKS : TIMEOUT_TICKS;
  localparam int unsigned CNT_W     = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAD,
    ST_MOVE_UP,
    ST_MOVE_DN,
    ST_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [1:0]       pos_q, pos_d;
  logic [1:0]       pend_pos_q, pend_pos_d;
  logic             pend_v_q, pend_v_d;
  logic             subir_q, subir_d, bajar_q, bajar_d;
  logic             busy_q, busy_d, fault_q, fault_d;
  logic             gu_q, gu_d, ga_q, ga_d;
  logic             user_req, auto_req, accept, go_up;
  logic [1:0]       new_tgt;

  function automatic logic at_pos(input logic [1:0] p, input logic lo,
                                  input logic mid, input logic hi);
    case (p)
      2'b01:   at_pos = lo;
      2'b10:   at_pos = mid;
      2'b11:   at_pos = hi;
      default: at_pos = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    pos_d      = pos_q;
    pend_v_d   = pend_v_q;
    pend_pos_d = pend_pos_q;
    gu_d       = 1'b0;
    ga_d       = 1'b0;
    accept     = 1'b0;
    new_tgt    = 2'b00;
    user_req   = req.user_valid && (req.user_pos != 2'b00);
    auto_req   = req.auto_en && req.auto_valid && (req.auto_pos != 2'b00);
    // Unknown position: everything except the bottom is reached by raising.
    go_up      = (pos_q == 2'b00) ? (tgt_q != 2'b01) : (tgt_q > pos_q);

    if (s_sup && s_inf && state_q != ST_FAULT) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (user_req || pend_v_q) begin
            accept   = 1'b1;
            gu_d     = 1'b1;
            pend_v_d = 1'b0;
            new_tgt  = user_req ? req.user_pos : pend_pos_q;
          end else if (auto_req) begin
            accept  = 1'b1;
            ga_d    = 1'b1;
            new_tgt = req.auto_pos;
          end
          if (accept) begin
            tgt_d = new_tgt;
            if (!(new_tgt == pos_q && at_pos(new_tgt, s_inf, s_med, s_sup))) begin
              state_d = ST_DEAD;
              cnt_d   = CNT_W'(DEAD_TICKS);
            end
          end
        end
        ST_DEAD: begin
          if (cnt_q == '0 || (tick && cnt_q == CNT_W'(1))) begin
            state_d = go_up ? ST_MOVE_UP : ST_MOVE_DN;
`ifdef PERSIANA_WATCHDOG_EN
            cnt_d   = CNT_W'(TIMEOUT_TICKS);
`else
            cnt_d   = '0;
`endif
          end else if (tick) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_MOVE_UP, ST_MOVE_DN: begin
          if (at_pos(tgt_q, s_inf, s_med, s_sup)) begin
            state_d = ST_IDLE;
            pos_d   = tgt_q;
          end else if (state_q == ST_MOVE_UP && s_sup) begin
            state_d = ST_IDLE;
            pos_d   = 2'b11;
          end else if (state_q == ST_MOVE_DN && s_inf) begin
            state_d = ST_IDLE;
            pos_d   = 2'b01;
          end
`ifdef PERSIANA_WATCHDOG_EN
          else if (tick) begin
            if (cnt_q <= CNT_W'(1)) state_d = ST_FAULT;
            else                    cnt_d   = cnt_q - CNT_W'(1);
          end
`endif
        end
        default: ;
      endcase

      if ((state_q == ST_DEAD || state_q == ST_MOVE_UP || state_q == ST_MOVE_DN) && user_req) begin
        pend_v_d   = 1'b1;
        pend_pos_d = req.user_pos;
      end
    end

    subir_d = (state_d == ST_MOVE_UP);
    bajar_d = (state_d == ST_MOVE_DN);
    busy_d  = (state_d != ST_IDLE);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tgt_q      <= 2'b00;
      pos_q      <= 2'b00;
      pend_v_q   <= 1'b0;
      pend_pos_q <= 2'b00;
      subir_q    <= 1'b0;
      bajar_q    <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      gu_q       <= 1'b0;
      ga_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      pos_q      <= pos_d;
      pend_v_q   <= pend_v_d;
      pend_pos_q <= pend_pos_d;
      subir_q    <= subir_d;
      bajar_q    <= bajar_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      gu_q       <= gu_d;
      ga_q       <= ga_d;
    end
  end

  assign subir          = subir_q;
  assign bajar          = bajar_q;
  assign busy           = busy_q;
  assign fault          = fault_q;
  assign pos_cur        = pos_q;
  assign req.grant_user = gu_q;
  assign req.grant_auto = ga_q;
endmodule

// File: tb/tb_blind_motor_arbiter.sv
// Randomized bench for blind_motor_arbiter; expectations come from a transaction-level
// model of blind position, the pending user request and tick budgets.
module tb_blind_motor_arbiter;
  localparam int DEAD = 4;
  localparam int TMO  = 200;

  logic       clk = 1'b0;
  logic       reset, tick;
  logic       s_inf, s_med, s_sup;
  logic       subir, bajar, busy, fault;
  logic [1:0] pos_cur;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] m_pos;
  logic       m_pend_v;
  logic [1:0] m_pend_pos;
  bit         inj_en;

  blind_motor_arbiter_if bus ();

  blind_motor_arbiter #(.DEAD_TICKS(DEAD), .TIMEOUT_TICKS(TMO)) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .req     (bus),
    .s_inf   (s_inf),
    .s_med   (s_med),
    .s_sup   (s_sup),
    .subir   (subir),
    .bajar   (bajar),
    .busy    (busy),
    .fault   (fault),
    .pos_cur (pos_cur)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sens(input logic [1:0] p);
    s_inf = (p == 2'b01);
    s_med = (p == 2'b10);
    s_sup = (p == 2'b11);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick = 1'b0;
    bus.user_valid = 1'b0;
    bus.auto_valid = 1'b0;
    set_sens(2'b00);
    cyc();
    reset = 1'b0;
    m_pos = 2'b00;
    m_pend_v = 1'b0;
    chk_eq("rst_drive", {subir, bajar}, 2'b00);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_fault", fault, 1'b0);
    chk_eq("rst_pos", pos_cur, 2'b00);
    chk_eq("rst_grants", {bus.grant_user, bus.grant_auto}, 2'b00);
  endtask

  task automatic user_req(input logic [1:0] p);
    bus.user_valid = 1'b1;
    bus.user_pos = p;
    cyc();
    bus.user_valid = 1'b0;
    chk_eq("usr_grant_user", bus.grant_user, 1'b1);
    chk_eq("usr_grant_auto", bus.grant_auto, 1'b0);
  endtask

  // Random requests while busy: users land in the one-deep pending slot, autos vanish.
  task automatic maybe_inject();
    bus.user_valid = 1'b0;
    bus.auto_valid = 1'b0;
    if (inj_en) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.user_valid = 1'b1;
        bus.user_pos = 2'($urandom_range(0, 3));
        if (bus.user_pos != 2'b00) begin
          m_pend_v = 1'b1;
          m_pend_pos = bus.user_pos;
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        bus.auto_en = 1'b1;
        bus.auto_valid = 1'b1;
        bus.auto_pos = 2'($urandom_range(1, 3));
      end
    end
  endtask

  task automatic dead_phase(input logic [1:0] t, output bit up);
    int ticks;
    bit moving;
    ticks = 0;
    moving = 1'b0;
    up = (m_pos == 2'b00) ? (t != 2'b01) : (t > m_pos);
    set_sens(2'b00);
    for (int i = 0; i < 100 && !moving; i++) begin
      maybe_inject();
      tick = (i > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc();
      ticks += int'(tick);
      moving = (ticks >= DEAD);
      chk_eq("dead_grants", {bus.grant_user, bus.grant_auto}, 2'b00);
      chk_eq("dead_drive", {subir, bajar}, moving ? (up ? 2'b10 : 2'b01) : 2'b00);
      chk_eq("dead_busy", busy, 1'b1);
    end
    tick = 1'b0;
    bus.user_valid = 1'b0;
    bus.auto_valid = 1'b0;
    chk_eq("dead_bound", moving, 1'b1);
  endtask

  task automatic move_phase(input logic [1:0] t, input bit up, input int ncyc, input bit endstop);
    logic [1:0] exp_pos;
    for (int i = 0; i < ncyc; i++) begin
      maybe_inject();
      tick = 1'($urandom_range(0, 1));
      cyc();
      chk_eq("move_drive", {subir, bajar}, up ? 2'b10 : 2'b01);
      chk_eq("move_grants", {bus.grant_user, bus.grant_auto}, 2'b00);
    end
    bus.user_valid = 1'b0;
    bus.auto_valid = 1'b0;
    tick = 1'b0;
    exp_pos = endstop ? (up ? 2'b11 : 2'b01) : t;
    set_sens(exp_pos);
    cyc();
    chk_eq("stop_drive", {subir, bajar}, 2'b00);
    chk_eq("stop_busy", busy, 1'b0);
    chk_eq("stop_pos", pos_cur, exp_pos);
    m_pos = exp_pos;
  endtask

  task automatic serve(input logic [1:0] t);
    bit up;
    chk_eq("acc_pos", pos_cur, m_pos);
    if (t == m_pos) begin
      chk_eq("same_pos_busy", busy, 1'b0);
      chk_eq("same_pos_drive", {subir, bajar}, 2'b00);
      return;
    end
    chk_eq("acc_busy", busy, 1'b1);
    chk_eq("acc_drive", {subir, bajar}, 2'b00);
    dead_phase(t, up);
    move_phase(t, up, $urandom_range(1, 30), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain_pending();
    logic [1:0] t;
    for (int k = 0; k < 10 && m_pend_v; k++) begin
      inj_en = (k < 3);
      bus.user_valid = 1'b0;
      bus.auto_en = 1'b1;
      bus.auto_valid = 1'b1;
      bus.auto_pos = 2'($urandom_range(1, 3));
      t = m_pend_pos;
      m_pend_v = 1'b0;
      cyc();
      bus.auto_valid = 1'b0;
      chk_eq("pend_grant_user", bus.grant_user, 1'b1);
      chk_eq("pend_grant_auto", bus.grant_auto, 1'b0);
      serve(t);
    end
    inj_en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit up;
    reset = 1'b1;
    tick = 1'b0;
    bus.user_valid = 1'b0;
    bus.user_pos = 2'b00;
    bus.auto_en = 1'b0;
    bus.auto_valid = 1'b0;
    bus.auto_pos = 2'b00;
    set_sens(2'b00);
    inj_en = 1'b0;
    m_pos = 2'b00;
    m_pend_v = 1'b0;
    m_pend_pos = 2'b00;

    // User beats auto in the same cycle; from unknown position 01 means lowering.
    do_reset();
    bus.auto_en = 1'b1;
    bus.auto_valid = 1'b1;
    bus.auto_pos = 2'b11;
    user_req(2'b01);
    bus.auto_valid = 1'b0;
    chk_eq("prio_busy", busy, 1'b1);
    dead_phase(2'b01, up);
    move_phase(2'b01, up, 5, 1'b0);

    // Raise to open, stop on the upper sensor.
    do_reset();
    user_req(2'b11);
    dead_phase(2'b11, up);
    move_phase(2'b11, up, 6, 1'b0);

    // Two user requests while raising: the newer one (half) is serviced after the stop.
    do_reset();
    user_req(2'b11);
    dead_phase(2'b11, up);
    bus.user_valid = 1'b1;
    bus.user_pos = 2'b01;
    cyc();
    chk_eq("pend1_grant", bus.grant_user, 1'b0);
    chk_eq("pend1_drive", {subir, bajar}, 2'b10);
    bus.user_pos = 2'b10;
    cyc();
    chk_eq("pend2_grant", bus.grant_user, 1'b0);
    chk_eq("pend2_drive", {subir, bajar}, 2'b10);
    bus.user_valid = 1'b0;
    m_pend_v = 1'b1;
    m_pend_pos = 2'b10;
    move_phase(2'b11, up, 2, 1'b1);
    bus.auto_en = 1'b1;
    bus.auto_valid = 1'b1;
    bus.auto_pos = 2'b01;
    cyc();
    bus.auto_valid = 1'b0;
    m_pend_v = 1'b0;
    chk_eq("rev_grant_user", bus.grant_user, 1'b1);
    chk_eq("rev_grant_auto", bus.grant_auto, 1'b0);
    chk_eq("rev_busy", busy, 1'b1);
    dead_phase(2'b10, up);
    move_phase(2'b10, up, 4, 1'b0);

    // Both end-stops while lowering latch FAULT until reset.
    do_reset();
    user_req(2'b01);
    dead_phase(2'b01, up);
    cyc();
    s_sup = 1'b1;
    s_inf = 1'b1;
    cyc();
    chk_eq("flt_fault", fault, 1'b1);
    chk_eq("flt_drive", {subir, bajar}, 2'b00);
    chk_eq("flt_busy", busy, 1'b1);
    set_sens(2'b00);
    bus.user_valid = 1'b1;
    bus.user_pos = 2'b11;
    for (int i = 0; i < 5; i++) cyc();
    bus.user_valid = 1'b0;
    chk_eq("flt_hold", fault, 1'b1);
    chk_eq("flt_hold_busy", busy, 1'b1);
    chk_eq("flt_no_grant", bus.grant_user, 1'b0);
    chk_eq("flt_hold_drive", {subir, bajar}, 2'b00);

    // Reset mid-lowering clears the known position; auto without auto_en is ignored.
    do_reset();
    user_req(2'b11);
    dead_phase(2'b11, up);
    move_phase(2'b11, up, 3, 1'b0);
    user_req(2'b01);
    dead_phase(2'b01, up);
    cyc();
    cyc();
    do_reset();
    bus.auto_en = 1'b0;
    bus.auto_valid = 1'b1;
    bus.auto_pos = 2'b11;
    cyc();
    bus.auto_valid = 1'b0;
    chk_eq("noauto_grant", {bus.grant_user, bus.grant_auto}, 2'b00);
    chk_eq("noauto_busy", busy, 1'b0);

    // Long raise with no sensor at all.
    do_reset();
    user_req(2'b11);
    dead_phase(2'b11, up);
    tick = 1'b1;
`ifdef PERSIANA_WATCHDOG_EN
    for (int i = 1; i < TMO; i++) cyc();
    chk_eq("wd_before_fault", fault, 1'b0);
    chk_eq("wd_before_drive", subir, 1'b1);
    cyc();
    chk_eq("wd_fault", fault, 1'b1);
    chk_eq("wd_drive", {subir, bajar}, 2'b00);
`else
    for (int i = 0; i < 300; i++) cyc();
    chk_eq("nowd_fault", fault, 1'b0);
    chk_eq("nowd_drive", {subir, bajar}, 2'b10);
`endif
    tick = 1'b0;
    do_reset();

    inj_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [1:0] up_p, au_p;
      bit uv, ae, av, gu, ga;
      uv   = 1'($urandom_range(0, 1));
      ae   = 1'($urandom_range(0, 1));
      av   = 1'($urandom_range(0, 1));
      up_p = 2'($urandom_range(0, 3));
      au_p = 2'($urandom_range(0, 3));
      bus.user_valid = uv;
      bus.user_pos = up_p;
      bus.auto_en = ae;
      bus.auto_valid = av;
      bus.auto_pos = au_p;
      cyc();
      bus.user_valid = 1'b0;
      bus.auto_valid = 1'b0;
      gu = uv && (up_p != 2'b00);
      ga = !gu && ae && av && (au_p != 2'b00);
      chk_eq("rnd_grant_user", bus.grant_user, gu);
      chk_eq("rnd_grant_auto", bus.grant_auto, ga);
      if (gu)      serve(up_p);
      else if (ga) serve(au_p);
      else         chk_eq("rnd_idle_busy", busy, 1'b0);
      drain_pending();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
